if_redirect_ctrl: RTL and testbench

- Sequencer for the instruction-fetch pipe stage. It arbitrates PC redirect sources: the EX-stage branch resolution and the ID-stage jump decode.
- It merges these with the load-use stall and an external hold, and drives the IF stage's en, branch_taken, jump and target inputs plus the IF/ID and ID/EX flush lines.
- A redirect that arrives while fetch is held is buffered and replayed when the hold releases.

---
 rtl/if_redirect_ctrl_pkg.sv | 21 ++
 rtl/if_redirect_pend.sv | 56 +++++
 rtl/if_redirect_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_if_redirect_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: FSM state
// encodings, pending-redirect kinds and default widths.
package if_redirect_ctrl_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int HOLD_MAX_DEF = 255;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPLAY = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PK_NONE   = 2'd0,
        PK_JUMP   = 2'd1,
        PK_BRANCH = 2'd2
    } pend_kind_e;

endpackage

// File: rtl/if_redirect_pend.sv
// Single-entry buffer for a redirect that arrives while fetch is held.
// A branch always overwrites the entry. A jump is taken only when the
// entry is empty or already holds a jump, so an older branch is never
// lost to a younger jump. Capture wins over clear in the same cycle.
module if_redirect_pend
    import if_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_branch,
    input  logic              capture_jump,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              clear,
    output logic              pend_valid,
    output pend_kind_e        pend_kind,
    output logic [ADDR_W-1:0] pend_target
);

    pend_kind_e        kind_q, kind_d;
    logic [ADDR_W-1:0] target_q, target_d;

    // Next entry: branch > jump (unless a branch is held) > clear > keep.
    always_comb begin
        kind_d   = kind_q;
        target_d = target_q;
        if (capture_branch) begin
            kind_d   = PK_BRANCH;
            target_d = branch_target;
        end else if (capture_jump && kind_q != PK_BRANCH) begin
            kind_d   = PK_JUMP;
            target_d = jump_target;
        end else if (clear) begin
            kind_d   = PK_NONE;
            target_d = '0;
        end
    end

    // Entry register, emptied by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q   <= PK_NONE;
            target_q <= '0;
        end else begin
            kind_q   <= kind_d;
            target_q <= target_d;
        end
    end

    assign pend_valid  = (kind_q != PK_NONE);
    assign pend_kind   = kind_q;
    assign pend_target = target_q;

endmodule

// File: rtl/if_redirect_ctrl.sv
// Fetch-stage sequencer: arbitrates EX branch and ID jump redirects
// against the load-use stall and an external hold, drives the IF stage
// enable/select/target lines and the IF/ID, ID/EX flushes. Redirects
// seen while held are buffered and replayed on release.
// Optional statistics counters are built when IF_REDIRECT_STATS_EN is
// defined (stat_branches, stat_jumps, stat_stalls).
// Handshake: there is no valid/ready pairing; every request input is a
// level sampled in the cycle it is presented, and all outputs respond
// combinationally in that same cycle.
module if_redirect_ctrl
    import if_redirect_ctrl_pkg::*;
#(
    parameter  int ADDR_W   = ADDR_W_DEF,
    parameter  int HOLD_MAX = HOLD_MAX_DEF,
    localparam int HC_W     = $clog2(HOLD_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_target,
    input  logic              hazard_stall,
    input  logic              ext_hold,
    output logic              if_en,
    output logic              if_branch_taken,
    output logic              if_jump,
    output logic [ADDR_W-1:0] if_branch_address,
    output logic [ADDR_W-1:0] if_jump_address,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              pend_valid,
    output logic [HC_W-1:0]   hold_cycles,
`ifdef IF_REDIRECT_STATS_EN
    output logic [15:0]       stat_branches,
    output logic [15:0]       stat_jumps,
    output logic [15:0]       stat_stalls,
`endif
    output state_e            dbg_state
);

    localparam logic [HC_W-1:0] HOLD_MAX_C = HC_W'(HOLD_MAX);

    state_e            state_q, state_d;
    logic [HC_W-1:0]   hold_q, hold_d;

    logic              cap_branch, cap_jump, pend_clear;
    pend_kind_e        pend_kind;
    logic [ADDR_W-1:0] pend_target;

    if_redirect_pend #(.ADDR_W(ADDR_W)) u_pend (
        .clk            (clk),
        .reset_n        (reset_n),
        .capture_branch (cap_branch),
        .capture_jump   (cap_jump),
        .branch_target  (ex_branch_target),
        .jump_target    (id_jump_target),
        .clear          (pend_clear),
        .pend_valid     (pend_valid),
        .pend_kind      (pend_kind),
        .pend_target    (pend_target)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: hold dominates everywhere except the boot cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    state_d = ext_hold ? ST_HOLD : ST_RUN;
            ST_HOLD:   state_d = ext_hold   ? ST_HOLD   :
                                 pend_valid ? ST_REPLAY : ST_RUN;
            ST_REPLAY: state_d = ext_hold ? ST_HOLD : ST_RUN;
            default:   state_d = ST_BOOT;
        endcase
    end

    // Outputs and pending-buffer control from state, pending entry, inputs.
    always_comb begin
        if_en             = 1'b0;
        if_branch_taken   = 1'b0;
        if_jump           = 1'b0;
        if_branch_address = '0;
        if_jump_address   = '0;
        flush_ifid        = 1'b0;
        flush_idex        = 1'b0;
        cap_branch        = 1'b0;
        cap_jump          = 1'b0;
        pend_clear        = 1'b0;
        if (state_q != ST_BOOT && ext_hold) begin
            // Held: fetch frozen, redirects go to the buffer. A stalled
            // jump is not captured since it will re-present later.
            flush_idex = hazard_stall;
            cap_branch = ex_branch_taken;
            cap_jump   = id_jump && !hazard_stall;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        if_en             = 1'b1;
                        if_branch_taken   = 1'b1;
                        if_branch_address = ex_branch_target;
                        flush_ifid        = 1'b1;
                        flush_idex        = 1'b1;
                    end else if (hazard_stall) begin
                        flush_idex = 1'b1;
                    end else if (id_jump) begin
                        if_en           = 1'b1;
                        if_jump         = 1'b1;
                        if_jump_address = id_jump_target;
                        flush_ifid      = 1'b1;
                    end else begin
                        if_en = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Release cycle: still frozen, last chance to capture.
                    flush_idex = hazard_stall;
                    cap_branch = ex_branch_taken;
                    cap_jump   = id_jump && !hazard_stall;
                end
                ST_REPLAY: begin
                    if_en      = 1'b1;
                    pend_clear = 1'b1;
                    if (ex_branch_taken) begin
                        if_branch_taken   = 1'b1;
                        if_branch_address = ex_branch_target;
                        flush_ifid        = 1'b1;
                        flush_idex        = 1'b1;
                    end else if (pend_kind == PK_BRANCH) begin
                        if_branch_taken   = 1'b1;
                        if_branch_address = pend_target;
                        flush_ifid        = 1'b1;
                        flush_idex        = 1'b1;
                    end else if (pend_kind == PK_JUMP) begin
                        if_jump         = 1'b1;
                        if_jump_address = pend_target;
                        flush_ifid      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Hold-length counter: 1 on HOLD entry, saturating count while held,
    // otherwise keeps the length of the last hold.
    always_comb begin
        hold_d = hold_q;
        if (state_q != ST_HOLD && state_d == ST_HOLD) begin
            hold_d = HC_W'(1);
        end else if (state_q == ST_HOLD && ext_hold && hold_q != HOLD_MAX_C) begin
            hold_d = hold_q + HC_W'(1);
        end
    end

    // Hold-length register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign hold_cycles = hold_q;
    assign dbg_state   = state_q;

`ifdef IF_REDIRECT_STATS_EN
    logic [15:0] st_br_q, st_jmp_q, st_stall_q;

    // Saturating event counters for branch, jump and non-boot stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_br_q    <= '0;
            st_jmp_q   <= '0;
            st_stall_q <= '0;
        end else begin
            if (if_branch_taken && st_br_q != 16'hFFFF) begin
                st_br_q <= st_br_q + 16'd1;
            end
            if (if_jump && st_jmp_q != 16'hFFFF) begin
                st_jmp_q <= st_jmp_q + 16'd1;
            end
            if (!if_en && state_q != ST_BOOT && st_stall_q != 16'hFFFF) begin
                st_stall_q <= st_stall_q + 16'd1;
            end
        end
    end

    assign stat_branches = st_br_q;
    assign stat_jumps    = st_jmp_q;
    assign stat_stalls   = st_stall_q;
`endif

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// Bench for if_redirect_ctrl: stimulus rows carry their expected output
// vector, which is queued on drive and popped when the outputs are sampled
// two time units after the driving negedge.
module tb_if_redirect_ctrl;
  import if_redirect_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int HW = 8;
  localparam int EW = 26;

  logic          clk;
  logic          reset_n;
  logic          ex_branch_taken;
  logic [AW-1:0] ex_branch_target;
  logic          id_jump;
  logic [AW-1:0] id_jump_target;
  logic          hazard_stall;
  logic          ext_hold;
  logic          if_en;
  logic          if_branch_taken;
  logic          if_jump;
  logic [AW-1:0] if_branch_address;
  logic [AW-1:0] if_jump_address;
  logic          flush_ifid;
  logic          flush_idex;
  logic          pend_valid;
  logic [HW-1:0] hold_cycles;
  state_e        dbg_state;
`ifdef IF_REDIRECT_STATS_EN
  logic [15:0]   stat_branches;
  logic [15:0]   stat_jumps;
  logic [15:0]   stat_stalls;
`endif

  int vectors;
  int miscompares;

  logic [EW-1:0] exp_q[$];

  typedef struct packed {
    logic          br;
    logic [AW-1:0] bt;
    logic          j;
    logic [AW-1:0] jt;
    logic          hz;
    logic          hold;
    logic [EW-1:0] e;
  } row_t;

  if_redirect_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ex_branch_taken   (ex_branch_taken),
    .ex_branch_target  (ex_branch_target),
    .id_jump           (id_jump),
    .id_jump_target    (id_jump_target),
    .hazard_stall      (hazard_stall),
    .ext_hold          (ext_hold),
    .if_en             (if_en),
    .if_branch_taken   (if_branch_taken),
    .if_jump           (if_jump),
    .if_branch_address (if_branch_address),
    .if_jump_address   (if_jump_address),
    .flush_ifid        (flush_ifid),
    .flush_idex        (flush_idex),
    .pend_valid        (pend_valid),
    .hold_cycles       (hold_cycles),
`ifdef IF_REDIRECT_STATS_EN
    .stat_branches     (stat_branches),
    .stat_jumps        (stat_jumps),
    .stat_stalls       (stat_stalls),
`endif
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ev(logic en, logic bt, logic j, logic [AW-1:0] ba,
                                       logic [AW-1:0] ja, logic fi, logic fe, logic pv);
    return {en, bt, j, ba, ja, fi, fe, pv};
  endfunction

  function automatic logic [EW-1:0] dut_vec();
    return {if_en, if_branch_taken, if_jump, if_branch_address, if_jump_address,
            flush_ifid, flush_idex, pend_valid};
  endfunction

  function automatic row_t rw(logic br, logic [AW-1:0] bt, logic j, logic [AW-1:0] jt,
                              logic hz, logic hold, logic [EW-1:0] e);
    row_t r;
    r.br = br; r.bt = bt; r.j = j; r.jt = jt; r.hz = hz; r.hold = hold; r.e = e;
    return r;
  endfunction

  // driver: apply one row at the negedge and queue its expectation
  task automatic drive(input row_t r);
    @(negedge clk);
    ex_branch_taken  = r.br;
    ex_branch_target = r.bt;
    id_jump          = r.j;
    id_jump_target   = r.jt;
    hazard_stall     = r.hz;
    ext_hold         = r.hold;
    exp_q.push_back(r.e);
  endtask

  task automatic idle_inputs();
    ex_branch_taken  = 1'b0;
    ex_branch_target = '0;
    id_jump          = 1'b0;
    id_jump_target   = '0;
    hazard_stall     = 1'b0;
    ext_hold         = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #2;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
    got = dut_vec(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h exp=%h", got, exp);
    end
    vectors++;
    if (hold_cycles !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hold_cycles got=%0d exp=0", hold_cycles);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    got = dut_vec(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL boot_cycle got=%h exp=%h", got, exp);
    end
    for (int i = 0; i < 3; i++) rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL run_idle[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_branch_priority();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    rows.push_back(rw(1, 10'h040, 1, 10'h080, 1, 0, ev(1, 1, 0, 10'h040, 0, 1, 1, 0)));
    rows.push_back(rw(1, 10'h3FF, 0, 0, 0, 0, ev(1, 1, 0, 10'h3FF, 0, 1, 1, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL branch_priority[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_stall_jump();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    rows.push_back(rw(0, 0, 1, 10'h080, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 0)));
    rows.push_back(rw(0, 0, 1, 10'h080, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 0)));
    rows.push_back(rw(0, 0, 1, 10'h080, 0, 0, ev(1, 0, 1, 0, 10'h080, 1, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stall_jump[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_hold_replay();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    rows.push_back(rw(0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 1, 10'h080, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 1, 1, ev(0, 0, 0, 0, 0, 0, 1, 1)));
    rows.push_back(rw(1, 10'h040, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 1, 10'h100, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 1, 0, 10'h040, 0, 1, 1, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold_replay[%0d] got=%h exp=%h", i, got, exp);
      end
      if (i == 5 || i == 7) begin
        vectors++;
        if (hold_cycles !== 8'd5) begin
          miscompares++;
          $display("FAIL hold_len[%0d] got=%0d exp=5", i, hold_cycles);
        end
      end
    end
  endtask

  task automatic test_replay_variants();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    // jump captured on the hold-entry cycle, replayed on release
    rows.push_back(rw(0, 0, 1, 10'h123, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 1, 0, 10'h123, 1, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    // live branch in the replay cycle overrides the buffered jump
    rows.push_back(rw(0, 0, 1, 10'h055, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(1, 10'h066, 0, 0, 0, 0, ev(1, 1, 0, 10'h066, 0, 1, 1, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    // hold reasserted during replay keeps the entry for a later replay
    rows.push_back(rw(0, 0, 1, 10'h011, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 1, 0, 10'h011, 1, 0, 1)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    // stalled jump during hold is not buffered: release goes straight to run
    rows.push_back(rw(0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 1, 10'h022, 1, 1, ev(0, 0, 0, 0, 0, 0, 1, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL replay_variants[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    vectors++;
    if (hold_cycles !== 8'd2) begin
      miscompares++;
      $display("FAIL hold_len_last got=%0d exp=2", hold_cycles);
    end
  endtask

  task automatic test_hold_saturate();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    for (int i = 0; i < 260; i++) rows.push_back(rw(0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL hold_sat[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    vectors++;
    if (hold_cycles !== 8'd255) begin
      miscompares++;
      $display("FAIL hold_saturation got=%0d exp=255", hold_cycles);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    rows.push_back(rw(1, 10'h040, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0)));
    rows.push_back(rw(0, 0, 0, 0, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 1)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mid_hold_setup[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
    #2;
    reset_n = 1'b0;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    got = dut_vec(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mid_hold_async_reset got=%h exp=%h", got, exp);
    end
    vectors++;
    if (hold_cycles !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_hold_reset_len got=%0d exp=0", hold_cycles);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    got = dut_vec(); exp = exp_q.pop_front(); vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL mid_hold_boot got=%h exp=%h", got, exp);
    end
    rows.delete();
    for (int i = 0; i < 2; i++) rows.push_back(rw(0, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mid_hold_no_replay[%0d] got=%h exp=%h", i, got, exp);
      end
    end
  endtask

`ifdef IF_REDIRECT_STATS_EN
  task automatic test_stats();
    logic [EW-1:0] got, exp;
    row_t rows[$];
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++)
      rows.push_back(rw(1, 10'(i + 1), 0, 0, 0, 0, ev(1, 1, 0, 10'(i + 1), 0, 1, 1, 0)));
    for (int i = 0; i < 2; i++)
      rows.push_back(rw(0, 0, 1, 10'(i + 8), 0, 0, ev(1, 0, 1, 0, 10'(i + 8), 1, 0, 0)));
    for (int i = 0; i < 4; i++)
      rows.push_back(rw(0, 0, 0, 0, 1, 0, ev(0, 0, 0, 0, 0, 0, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      #2;
      got = dut_vec(); exp = exp_q.pop_front(); vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stats_stim[%0d] got=%h exp=%h", i, got, exp);
      end
    end
    @(negedge clk);
    idle_inputs();
    vectors++;
    if (stat_branches !== 16'd3) begin
      miscompares++;
      $display("FAIL stat_branches got=%0d exp=3", stat_branches);
    end
    vectors++;
    if (stat_jumps !== 16'd2) begin
      miscompares++;
      $display("FAIL stat_jumps got=%0d exp=2", stat_jumps);
    end
    vectors++;
    if (stat_stalls !== 16'd4) begin
      miscompares++;
      $display("FAIL stat_stalls got=%0d exp=4", stat_stalls);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_branch_priority();
    test_stall_jump();
    test_hold_replay();
    test_replay_variants();
    test_hold_saturate();
    test_reset_mid_hold();
`ifdef IF_REDIRECT_STATS_EN
    test_stats();
`endif
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
